// File: rtl/text_field_writer.sv
// text_field_writer
//   Renders a 32-bit unsigned value as ASCII hex or decimal digits and writes
//   them, one character per cycle, into the character buffer write port.
//   Decimal values are converted by a 32-cycle sequential double-dabble.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_*             field request (row, leftmost column, value, base, digit count)
//   req_ready         idle and able to accept a request
//   busy              request in progress (CONV, WRITE, DONE)
//   done              one-cycle pulse after the last character
//   cb_wr_addr/en/data character buffer write port, address = {row, col}
//
// Build option:
//   TFW_ZERO_BLANK_EN  when defined, leading zero digits are written as spaces
//                      (least significant digit always printed).
//
// state | meaning
// IDLE  | ready for a request
// CONV  | binary to BCD conversion, 32 cycles
// WRITE | one character per cycle
// DONE  | done pulse, then back to IDLE
module text_field_writer #(
  parameter int COL_W = 5,
  parameter int ROW_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ROW_W-1:0]       req_row,
  input  logic [COL_W-1:0]       req_col,
  input  logic [31:0]            req_value,
  input  logic                   req_dec,
  input  logic [3:0]             req_ndigits,
  output logic                   busy,
  output logic                   done,
  output logic [COL_W+ROW_W-1:0] cb_wr_addr,
  output logic                   cb_wr_en,
  output logic [7:0]             cb_wr_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef TFW_ZERO_BLANK_EN
  localparam logic ZERO_BLANK = 1'b1;
`else
  localparam logic ZERO_BLANK = 1'b0;
`endif

  logic [1:0]       state;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [3:0]       n_q;
  logic [3:0]       k_q;
  logic             lead_q;
  logic [39:0]      dig_q;   // hex nibbles or BCD digits, digit i at [4i+3:4i]
  logic [31:0]      val_q;
  logic [4:0]       cnt_q;

  logic             accept;
  logic [3:0]       req_n;
  logic [39:0]      adj;
  logic [39:0]      bcd_next;

  // Character generator inputs, selected by which transition emits a write
  logic [39:0]      wr_d;
  logic [3:0]       wr_n;
  logic [3:0]       wr_k;
  logic             wr_lead;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col0;
  logic [3:0]       wr_idx;
  logic [3:0]       wr_digit;
  logic [7:0]       wr_char;
  logic             wr_lead_nx;
  logic [COL_W+ROW_W-1:0] wr_addr;

  assign accept = req_valid & req_ready & (state == S_IDLE);

  always_comb begin
    req_n = req_ndigits;
    if (req_ndigits == 4'd0)
      req_n = 4'd1;
    else if (req_dec && req_ndigits > 4'd10)
      req_n = 4'd10;
    else if (!req_dec && req_ndigits > 4'd8)
      req_n = 4'd8;
  end

  // One double-dabble step: adjust nibbles >= 5, then shift in the next bit
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < 10; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_next = 40'({adj, val_q[31]});
  end

  always_comb begin
    wr_d    = dig_q;
    wr_n    = n_q;
    wr_k    = k_q + 4'd1;
    wr_lead = lead_q;
    wr_row  = row_q;
    wr_col0 = col_q;
    case (state)
      S_IDLE: begin
        wr_d    = {8'h00, req_value};
        wr_n    = req_n;
        wr_k    = 4'd0;
        wr_lead = 1'b1;
        wr_row  = req_row;
        wr_col0 = req_col;
      end
      S_CONV: begin
        wr_d    = bcd_next;
        wr_k    = 4'd0;
        wr_lead = 1'b1;
      end
      default: ;
    endcase
    wr_idx     = wr_n - 4'd1 - wr_k;
    wr_digit   = 4'(wr_d >> {wr_idx, 2'b00});
    wr_lead_nx = wr_lead && (wr_digit == 4'd0);
    if (ZERO_BLANK && wr_lead_nx && (wr_idx != 4'd0))
      wr_char = 8'h20;
    else if (wr_digit < 4'd10)
      wr_char = {4'h3, wr_digit};
    else
      wr_char = 8'h37 + {4'h0, wr_digit};
    wr_addr = {wr_row, wr_col0 + COL_W'(wr_k)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cb_wr_en   <= 1'b0;
      cb_wr_addr <= '0;
      cb_wr_data <= 8'h20;
      row_q      <= '0;
      col_q      <= '0;
      n_q        <= 4'd1;
      k_q        <= 4'd0;
      lead_q     <= 1'b1;
      dig_q      <= '0;
      val_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            row_q     <= req_row;
            col_q     <= req_col;
            n_q       <= req_n;
            k_q       <= 4'd0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_dec) begin
              state <= S_CONV;
              dig_q <= '0;
              val_q <= req_value;
              cnt_q <= 5'd31;
            end else begin
              state      <= S_WRITE;
              dig_q      <= {8'h00, req_value};
              cb_wr_en   <= 1'b1;
              cb_wr_addr <= wr_addr;
              cb_wr_data <= wr_char;
              lead_q     <= wr_lead_nx;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_CONV: begin
          dig_q <= bcd_next;
          val_q <= {val_q[30:0], 1'b0};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state      <= S_WRITE;
            cb_wr_en   <= 1'b1;
            cb_wr_addr <= wr_addr;
            cb_wr_data <= wr_char;
            lead_q     <= wr_lead_nx;
          end
        end
        S_WRITE: begin
          if (k_q == n_q - 4'd1) begin
            state    <= S_DONE;
            cb_wr_en <= 1'b0;
            done     <= 1'b1;
          end else begin
            k_q        <= k_q + 4'd1;
            cb_wr_en   <= 1'b1;
            cb_wr_addr <= wr_addr;
            cb_wr_data <= wr_char;
            lead_q     <= wr_lead_nx;
          end
        end
        default: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_field_writer.sv
// Testbench for text_field_writer: randomized and directed field requests,
// expected characters computed arithmetically and checked by a monitor.
module tb_text_field_writer;

  localparam int COL_W = 5;
  localparam int ROW_W = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [ROW_W-1:0]       req_row = '0;
  logic [COL_W-1:0]       req_col = '0;
  logic [31:0]            req_value = '0;
  logic                   req_dec = 1'b0;
  logic [3:0]             req_ndigits = '0;
  logic                   busy;
  logic                   done;
  logic [COL_W+ROW_W-1:0] cb_wr_addr;
  logic                   cb_wr_en;
  logic [7:0]             cb_wr_data;

  text_field_writer #(.COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .req_value(req_value),
    .req_dec(req_dec), .req_ndigits(req_ndigits),
    .busy(busy), .done(done),
    .cb_wr_addr(cb_wr_addr), .cb_wr_en(cb_wr_en), .cb_wr_data(cb_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t wq[$];
  int   dq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: digit i of (value mod base^n); leading zeros optionally blank
  function automatic int clamp_n(input bit dec, input int nd);
    if (nd == 0) return 1;
    if (dec && nd > 10) return 10;
    if (!dec && nd > 8) return 8;
    return nd;
  endfunction

  task automatic push_expect(input int row, input int col, input longint unsigned val,
                             input bit dec, input int nd, input int a);
    int n, lat, i, ch;
    longint unsigned base, bn, t, p, dig;
    n    = clamp_n(dec, nd);
    base = dec ? 10 : 16;
    lat  = dec ? 33 : 1;
    bn   = 1;
    for (int j = 0; j < n; j++) bn = bn * base;
    t = val % bn;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      i = n - 1 - k;
      p = 1;
      for (int j = 0; j < i; j++) p = p * base;
      dig = (t / p) % base;
      ch  = (dig < 10) ? int'(dig) + 48 : int'(dig) + 55;
`ifdef TFW_ZERO_BLANK_EN
      if (i > 0 && t < p) ch = 32;
`endif
      e.addr = row * 32 + ((col + k) % 32);
      e.data = ch;
      e.cyc  = a + lat + k;
      wq.push_back(e);
    end
    dq.push_back(a + lat + n);
  endtask

  // Monitor: every write and done pulse must match the head of its queue
  always @(negedge clk) begin
    if (cb_wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", {cb_wr_addr, cb_wr_data}, 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = wq.pop_front();
        chk("wr_addr", cb_wr_addr, e.addr);
        chk("wr_data", cb_wr_data, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", cyc, 64'hFFFF_FFFF);
      end else begin
        int dc;
        dc = dq.pop_front();
        chk("done_cycle", cyc, dc);
        chk("writes_before_done", wq.size() > 0 && wq[0].cyc < cyc, 0);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200 && req_ready !== 1'b1; i++) @(negedge clk);
    if (req_ready !== 1'b1) chk("ready_timeout", req_ready, 1);
  endtask

  task automatic drive(input int row, input int col, input logic [31:0] val,
                       input bit dec, input int nd);
    req_row     = ROW_W'(row);
    req_col     = COL_W'(col);
    req_value   = val;
    req_dec     = dec;
    req_ndigits = 4'(nd);
  endtask

  task automatic send(input int row, input int col, input logic [31:0] val,
                      input bit dec, input int nd);
    wait_ready();
    drive(row, col, val, dec, nd);
    req_valid = 1'b1;
    push_expect(row, col, longint'(val), dec, nd, cyc);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int a, n1;
    logic [31:0] v;

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", cb_wr_en, 0);
    chk("rst_addr", cb_wr_addr, 0);
    chk("rst_data", cb_wr_data, 8'h20);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // Directed cases
    send(5, 20, 32'h00AB12CD, 1'b0, 8);
    send(8, 19, 32'd1000, 1'b1, 5);
    send(0, 0, 32'hFFFFFFFF, 1'b1, 12);
    send(7, 3, 32'hFFFFFFFF, 1'b0, 0);
    send(3, 30, 32'h00001234, 1'b0, 4);
    send(2, 10, 32'h00012345, 1'b0, 2);
    send(1, 4, 32'd0, 1'b1, 6);
    send(1, 12, 32'd0, 1'b0, 15);

    // req_valid held high: second request accepted in the cycle after done
    wait_ready();
    drive(9, 1, 32'h00000ABC, 1'b0, 3);
    req_valid = 1'b1;
    n1 = 3;
    a  = cyc;
    push_expect(9, 1, 64'h0ABC, 1'b0, n1, a);
    @(posedge clk);
    @(negedge clk);
    drive(10, 2, 32'd98765, 1'b1, 5);
    push_expect(10, 2, 64'd98765, 1'b1, 5, a + n1 + 2);
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
    chk("held_valid_accept_cycle", cyc, a + n1 + 2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;

    // Request pulsed while busy is ignored
    send(11, 5, 32'd4242, 1'b1, 4);
    chk("busy_during_conv", busy, 1);
    drive(12, 6, 32'hDEADBEEF, 1'b0, 8);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;

    // Randomized requests
    for (int r = 0; r < 24; r++) begin
      v = $urandom();
      if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(8, 31);
      send($urandom_range(0, 63), $urandom_range(0, 31), v,
           1'($urandom_range(0, 1)), $urandom_range(0, 15));
    end

    // Reset in the middle of WRITE after 3 of 8 characters
    wait_ready();
    v = $urandom();
    drive(20, 25, v, 1'b0, 8);
    req_valid = 1'b1;
    a = cyc;
    push_expect(20, 25, longint'(v), 1'b0, 8, a);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < a + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_remaining", wq.size(), 5);
    wq.delete();
    dq.delete();
    chk("mid_rst_en", cb_wr_en, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_addr", cb_wr_addr, 0);
    chk("mid_rst_data", cb_wr_data, 8'h20);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", req_ready, 1);
    repeat (12) @(negedge clk);

    send(4, 28, 32'h0000BEEF, 1'b0, 6);
    send(6, 0, 32'd123456789, 1'b1, 10);

    for (int i = 0; i < 200 && (wq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
    chk("writes_drained", wq.size(), 0);
    chk("dones_drained", dq.size(), 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
